// File: rtl/reset_sequencer.sv
// Board reset sequencer: arbitrates ext/wdog/sw reset requests, asserts all
// domains together, then releases them one at a time, bit 0 first.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int DELAY       = 10,
    parameter int WIDTH       = 50,
    parameter int STAGGER     = 16
) (
    input  logic                   clk,
    input  logic                   async_reset_n_i,
    input  logic                   ext_reset_i,
    input  logic                   wdog_reset_i,
    input  logic                   sw_reset_i,
    output logic [NUM_DOMAINS-1:0] reset_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [1:0]             cause_o,
    output logic [7:0]             reset_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ASSERT, S_RELEASE} state_e;

    localparam logic [15:0]            DELAY_LAST   = 16'(DELAY - 1);
    localparam logic [15:0]            WIDTH_LAST   = 16'(WIDTH - 1);
    localparam logic [15:0]            STAGGER_LAST = 16'(STAGGER - 1);
    localparam logic [2:0]             LAST_IDX     = 3'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_ON       = '1;

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] reset_q, reset_d;
    logic                   done_q, done_d;
    logic [1:0]             cause_q, cause_d;
    logic [7:0]             count_q, count_d;
    logic                   ext_meta_q, ext_sync_q;
    logic                   req;
    logic [1:0]             req_cause;

    assign req       = ext_sync_q | wdog_reset_i | sw_reset_i;
    assign req_cause = ext_sync_q ? 2'd1 : (wdog_reset_i ? 2'd2 : 2'd3);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        reset_d = reset_q;
        done_d  = 1'b0;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    cause_d = req_cause;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    if (DELAY == 0) begin
                        state_d = S_ASSERT;
                        reset_d = ALL_ON;
                    end else begin
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                // requests here are absorbed: the sequence is already committed
                if (cnt_q == DELAY_LAST) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    reset_d = ALL_ON;
                end
            end
            S_ASSERT: begin
                if (req) begin
                    cnt_d   = '0;
                    cause_d = req_cause;
                end else if (cnt_q == WIDTH_LAST) begin
                    cnt_d = '0;
                    if (NUM_DOMAINS == 1) begin
                        reset_d = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        reset_d[0] = 1'b0;
                        state_d    = S_RELEASE;
                        idx_d      = 3'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (req) begin
                    reset_d = ALL_ON;
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    cause_d = req_cause;
                end else if (cnt_q == STAGGER_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_DOMAINS; i++)
                        if (idx_q == 3'(i)) reset_d[i] = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_ASSERT;
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_q    <= S_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            reset_q    <= ALL_ON;
            done_q     <= 1'b0;
            cause_q    <= 2'd0;
            count_q    <= 8'd0;
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            reset_q    <= reset_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
            ext_meta_q <= ext_reset_i;
            ext_sync_q <= ext_meta_q;
        end
    end

    assign reset_o       = reset_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign cause_o       = cause_q;
    assign reset_count_o = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edge numbers are
// relative to a per-scenario reference, outputs sampled 1ns after posedge.
module tb_reset_sequencer;

    logic       clk;
    logic       async_reset_n_i;
    logic       ext_reset_i;
    logic       wdog_reset_i;
    logic       sw_reset_i;
    logic [3:0] reset_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] cause_o;
    logic [7:0] reset_count_o;

    int n_chk = 0;
    int n_bad = 0;
    int ec    = 0;

    reset_sequencer dut (
        .clk             (clk),
        .async_reset_n_i (async_reset_n_i),
        .ext_reset_i     (ext_reset_i),
        .wdog_reset_i    (wdog_reset_i),
        .sw_reset_i      (sw_reset_i),
        .reset_o         (reset_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cause_o         (cause_o),
        .reset_count_o   (reset_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic goto(input int e);
        while (ec < e) step();
    endtask

    initial begin
        async_reset_n_i = 1'b0;
        ext_reset_i     = 1'b0;
        wdog_reset_i    = 1'b0;
        sw_reset_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reset_o", 32'(reset_o), 32'hF);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cause", 32'(cause_o), 32'd0);
        chk("rst_count", 32'(reset_count_o), 32'd0);

        // POR: next edge is edge 1
        async_reset_n_i = 1'b1;
        ec = 0;
        goto(49); chk("por_e49", 32'(reset_o), 32'hF);
        goto(50); chk("por_e50", 32'(reset_o), 32'hE);
        goto(65); chk("por_e65", 32'(reset_o), 32'hE);
        goto(66); chk("por_e66", 32'(reset_o), 32'hC);
        goto(82); chk("por_e82", 32'(reset_o), 32'h8);
        goto(97); chk("por_e97_done", 32'(done_o), 32'd0);
        goto(98); chk("por_e98", 32'(reset_o), 32'h0);
        chk("por_e98_done", 32'(done_o), 32'd1);
        chk("por_e98_busy", 32'(busy_o), 32'd0);
        goto(99); chk("por_e99_done", 32'(done_o), 32'd0);
        chk("por_cause", 32'(cause_o), 32'd0);
        chk("por_count", 32'(reset_count_o), 32'd0);

        // sw request at edge 1; wdog in DELAY must be absorbed
        goto(105);
        ec = 0;
        sw_reset_i = 1'b1; step(); sw_reset_i = 1'b0;
        chk("sw_delay_busy", 32'(busy_o), 32'd1);
        goto(4); wdog_reset_i = 1'b1; step(); wdog_reset_i = 1'b0;
        goto(10); chk("sw_e10", 32'(reset_o), 32'h0);
        goto(11); chk("sw_e11", 32'(reset_o), 32'hF);
        goto(60); chk("sw_e60", 32'(reset_o), 32'hF);
        goto(61); chk("sw_e61", 32'(reset_o), 32'hE);
        goto(77); chk("sw_e77", 32'(reset_o), 32'hC);
        goto(93); chk("sw_e93", 32'(reset_o), 32'h8);
        goto(109); chk("sw_e109", 32'(reset_o), 32'h0);
        chk("sw_done", 32'(done_o), 32'd1);
        chk("sw_cause", 32'(cause_o), 32'd3);
        chk("sw_count", 32'(reset_count_o), 32'd1);

        // wdog + sw together: wdog wins, counted once
        goto(115);
        ec = 0;
        sw_reset_i = 1'b1; wdog_reset_i = 1'b1; step();
        sw_reset_i = 1'b0; wdog_reset_i = 1'b0;
        goto(11); chk("both_e11", 32'(reset_o), 32'hF);
        goto(109); chk("both_e109", 32'(reset_o), 32'h0);
        chk("both_cause", 32'(cause_o), 32'd2);
        chk("both_count", 32'(reset_count_o), 32'd2);

        // wdog from IDLE, then sw in RELEASE at edge 71
        goto(115);
        ec = 0;
        wdog_reset_i = 1'b1; step(); wdog_reset_i = 1'b0;
        goto(61); chk("rel_e61", 32'(reset_o), 32'hE);
        chk("rel_cause_w", 32'(cause_o), 32'd2);
        goto(70);
        sw_reset_i = 1'b1; step(); sw_reset_i = 1'b0;
        chk("rel_e71", 32'(reset_o), 32'hF);
        chk("rel_cause_s", 32'(cause_o), 32'd3);
        chk("rel_count", 32'(reset_count_o), 32'd3);
        goto(120); chk("rel_e120", 32'(reset_o), 32'hF);
        goto(121); chk("rel_e121", 32'(reset_o), 32'hE);
        goto(169); chk("rel_e169", 32'(reset_o), 32'h0);
        chk("rel_done", 32'(done_o), 32'd1);

        // ext held for edges 1..200
        goto(175);
        ec = 0;
        ext_reset_i = 1'b1;
        goto(12); chk("ext_e12", 32'(reset_o), 32'h0);
        goto(13); chk("ext_e13", 32'(reset_o), 32'hF);
        chk("ext_cause", 32'(cause_o), 32'd1);
        goto(200); ext_reset_i = 1'b0;
        goto(251); chk("ext_e251", 32'(reset_o), 32'hF);
        goto(252); chk("ext_e252", 32'(reset_o), 32'hE);
        goto(300); chk("ext_e300", 32'(reset_o), 32'h0);
        chk("ext_done", 32'(done_o), 32'd1);
        chk("ext_count", 32'(reset_count_o), 32'd4);

        // async reset mid-RELEASE
        goto(305);
        ec = 0;
        sw_reset_i = 1'b1; step(); sw_reset_i = 1'b0;
        goto(70); chk("ar_pre", 32'(reset_o), 32'hE);
        async_reset_n_i = 1'b0;
        #1;
        chk("ar_reset_o", 32'(reset_o), 32'hF);
        chk("ar_cause", 32'(cause_o), 32'd0);
        chk("ar_count", 32'(reset_count_o), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd1);
        step(); step();
        async_reset_n_i = 1'b1;
        ec = 0;
        goto(49); chk("ar_e49", 32'(reset_o), 32'hF);
        goto(50); chk("ar_e50", 32'(reset_o), 32'hE);
        goto(98); chk("ar_e98", 32'(reset_o), 32'h0);
        chk("ar_done", 32'(done_o), 32'd1);

        // counter saturation over 256 accepted requests
        for (int i = 0; i < 256; i++) begin
            goto(ec + 3);
            ec = 0;
            sw_reset_i = 1'b1; step(); sw_reset_i = 1'b0;
            goto(109);
            if (i == 0) chk("sat_first", 32'(reset_count_o), 32'd1);
            if (i == 254) chk("sat_255", 32'(reset_count_o), 32'd255);
        end
        chk("sat_hold", 32'(reset_count_o), 32'd255);
        chk("sat_idle", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
